// File: rtl/scm_write_packer_32to64.sv
// Pairs 32-bit half-word writes into single-cycle 64-bit SCM register-file writes.
// Optional macro SCM_WPACK_ZERO_FILL_EN: unpaired halves are written zero-filled instead of dropped with err_o.
module scm_write_packer_32to64 #(
    parameter int WADDR_WIDTH = 5,
    parameter int WDATA_WIDTH = 64,
    parameter int IDATA_WIDTH = WDATA_WIDTH / 2,
    parameter int IADDR_WIDTH = WADDR_WIDTH + 1,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [IADDR_WIDTH-1:0] in_addr_i,
    input  logic [IDATA_WIDTH-1:0] in_data_i,
    input  logic                   flush_i,
    output logic                   WriteEnable,
    output logic [WADDR_WIDTH-1:0] WriteAddr,
    output logic [WDATA_WIDTH-1:0] WriteData,
    output logic                   err_o,
    output logic                   busy_o
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HALF = 1'b1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [0:0]             state;
    logic [WADDR_WIDTH-1:0] pend_word;
    logic                   pend_half;
    logic [IDATA_WIDTH-1:0] pend_data;
    logic [CNT_W-1:0]       cnt;
    logic                   we_q;

    logic                   beat;
    logic [WADDR_WIDTH-1:0] beat_word;
    logic                   beat_half;
    logic                   same_word;
    logic                   timeout_hit;
    logic                   do_pair;
    logic                   do_resolve;
    logic [WDATA_WIDTH-1:0] pair_data;
    logic [WDATA_WIDTH-1:0] fill_data;

    assign in_ready_o = !rst && !flush_i;
    assign beat       = in_valid_i && in_ready_o;
    assign beat_word  = in_addr_i[IADDR_WIDTH-1:1];
    assign beat_half  = in_addr_i[0];
    assign same_word  = (beat_word == pend_word);

    // Timeout only counts cycles with neither a beat nor a flush.
    assign timeout_hit = (TIMEOUT != 0) && (state == S_HALF) && !beat && !flush_i && (cnt == CNT_LAST);
    assign do_pair     = (state == S_HALF) && beat && same_word && (beat_half != pend_half);
    assign do_resolve  = (state == S_HALF) && (flush_i || timeout_hit || (beat && !same_word));

    assign pair_data = pend_half ? {pend_data, in_data_i} : {in_data_i, pend_data};
    assign fill_data = pend_half ? {pend_data, {IDATA_WIDTH{1'b0}}} : {{IDATA_WIDTH{1'b0}}, pend_data};

    assign busy_o = WriteEnable || we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pend_word   <= '0;
            pend_half   <= 1'b0;
            pend_data   <= '0;
            cnt         <= '0;
            we_q        <= 1'b0;
            WriteEnable <= 1'b0;
            WriteAddr   <= '0;
            WriteData   <= '0;
            err_o       <= 1'b0;
        end else begin
            WriteEnable <= 1'b0;
            err_o       <= 1'b0;
            we_q        <= WriteEnable;

            if (do_pair) begin
                WriteEnable <= 1'b1;
                WriteAddr   <= pend_word;
                WriteData   <= pair_data;
            end else if (do_resolve) begin
`ifdef SCM_WPACK_ZERO_FILL_EN
                WriteEnable <= 1'b1;
                WriteAddr   <= pend_word;
                WriteData   <= fill_data;
`else
                err_o       <= 1'b1;
`endif
            end

            if (beat) begin
                state     <= do_pair ? S_IDLE : S_HALF;
                pend_word <= beat_word;
                pend_half <= beat_half;
                pend_data <= in_data_i;
                cnt       <= '0;
            end else if (state == S_HALF) begin
                if (flush_i || timeout_hit)
                    state <= S_IDLE;
                else if (TIMEOUT != 0 && cnt != {CNT_W{1'b1}})
                    cnt <= cnt + 1'b1;
            end
        end
    end

`ifndef SCM_WPACK_ZERO_FILL_EN
    logic unused_fill;
    assign unused_fill = ^fill_data;
`endif
endmodule
